// File: rtl/adc_spi_rx.sv
// SPI master that reads one Width-bit conversion word from an ADC per start request.
// All outputs registered; sclk_o = clk_i / (2*ClkDiv), mode 0, MSB first.
module adc_spi_rx #(
  parameter int Width  = 16,
  parameter int ClkDiv = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             miso_i,
  output logic             sclk_o,
  output logic             cs_no,
  output logic [Width-1:0] dout_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int BitW = $clog2(Width + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(Width);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [Width-1:0] shreg_q, shreg_d;
  logic [Width-1:0] dout_q, dout_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b0;
        if (start_i) begin
          state_d = SETUP;
          shreg_d = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising sclk edge: the ADC has held this bit stable for a full low phase.
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[Width-2:0], miso_i};
            bit_d   = bit_q + 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitMax) begin
              state_d = DONE;
              dout_d  = shreg_q;
              valid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = QUIET;
        cnt_d   = '0;
      end
      QUIET: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sclk_d  = 1'b0;
      end
    endcase

    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  assign sclk_o  = sclk_q;
  assign cs_no   = cs_n_q;
  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule

// File: doc/adc_spi_rx.md
ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 SHALL have parameter Width, default 16, meaning bits per ADC conversion word (Width >= 2).
REQ-002 SHALL have parameter ClkDiv, default 4, meaning clk_i cycles per sclk_o half-period (ClkDiv >= 2).
REQ-003 SHALL have port clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  request one conversion read, sampled only in IDLE.
REQ-006 SHALL have port miso_i  input  1  serial data from ADC, MSB first.
REQ-007 SHALL have port sclk_o  output  1  serial clock to ADC, idle low.
REQ-008 SHALL have port cs_no  output  1  ADC chip select, active-low.
REQ-009 SHALL have port dout_o  output  Width  last complete received word.
REQ-010 SHALL have port valid_o  output  1  one-cycle pulse when dout_o updates.
REQ-011 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, SHIFT, DONE, QUIET; all outputs registered.
REQ-013 IDLE: cs_no=1, sclk_o=0, busy_o=0; start_i=1 at a rising edge -> SETUP at that edge, cs_no=0.
REQ-014 SETUP: cs_no=0, sclk_o=0 for exactly ClkDiv cycles, then -> SHIFT.
REQ-015 SHIFT: sclk_o = Width periods, each ClkDiv cycles low then ClkDiv cycles high; cs_no=0 throughout.
REQ-016 SHALL sample miso_i at the clk_i edge where sclk_o goes 0->1, shifting left: shreg <= {shreg[Width-2:0], miso_i}.
REQ-017 SHALL count sampled bits; after the Width-th high phase completes (sclk_o back to 0) -> DONE.
REQ-018 DONE entry edge: dout_o <= shreg, valid_o=1, cs_no=1, sclk_o=0; DONE lasts exactly one cycle, then -> QUIET.
REQ-019 DONE entry SHALL occur at the (2*Width+1)*ClkDiv-th rising edge after the edge sampling start_i (132 for defaults).
REQ-020 QUIET: cs_no=1, sclk_o=0, busy_o=1 for exactly ClkDiv cycles, then -> IDLE.
REQ-021 start_i SHALL be ignored in SETUP, SHIFT, DONE, QUIET; no queuing.
REQ-022 start_i held high continuously SHALL yield back-to-back transfers with cs_no high exactly ClkDiv+2 cycles between them.
REQ-023 dout_o SHALL hold its value between DONE states; valid_o SHALL be 0 outside DONE.
REQ-024 shreg SHALL be cleared to 0 on entry to SETUP.

Reset
REQ-025 rst_ni=0 SHALL immediately (asynchronously) force IDLE, cs_no=1, sclk_o=0, dout_o=0, valid_o=0, busy_o=0, shreg and counters 0.
REQ-026 Reset during any transfer SHALL abort it with no valid_o pulse and no dout_o update.
REQ-027 After rst_ni returns to 1, first start_i SHALL produce a complete normal transfer.

Verification
REQ-028 Reset: rst_ni=0 mid-clock -> cs_no=1, sclk_o=0, dout_o=0, valid_o=0, busy_o=0 without waiting for clk_i.
REQ-029 Defaults, ADC model drives 16'hA5C3 MSB first on sclk falling edges -> 16 sclk rising edges, cs_no low 132 cycles, valid_o one cycle at edge 132, dout_o=16'hA5C3.
REQ-030 start_i pulsed again at cycle 40 of a transfer -> exactly one valid_o pulse, dout_o from first transfer only.
REQ-031 rst_ni low after 8th sclk rising edge -> cs_no=1 at once, no valid_o; next transfer of 16'h0001 -> dout_o=16'h0001.
REQ-032 start_i held high, words 16'hFFFF then 16'h0000 -> dout_o=16'hFFFF then 16'h0000, cs_no high exactly 6 cycles between.
REQ-033 ClkDiv=2, Width=8, word 8'h81 -> valid_o at edge 34, dout_o=8'h81, sclk_o period 4 cycles.
